// File: rtl/vertex_detection_param.sv
// Streaming KERNEL_SIZE x KERNEL_SIZE vertex detector: thresholds each incoming column, keeps a
// running on-count over the last KERNEL_SIZE columns and flags convex/concave window centres.
module vertex_detection_param #(
  parameter int unsigned KERNEL_SIZE = 11,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned SUM_WIDTH   = $clog2(KERNEL_SIZE * KERNEL_SIZE + 1)
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] data_in,
  input  logic [10:0]                            hcount_in,
  input  logic [9:0]                             vcount_in,
  input  logic                                   data_valid_in,
  input  logic [PIXEL_WIDTH-1:0]                 on_thresh,
  input  logic [SUM_WIDTH-1:0]                   convex_max,
  input  logic [SUM_WIDTH-1:0]                   concave_min,
  input  logic [1:0]                             mode,
  output logic                                   data_valid_out,
  output logic [10:0]                            hcount_out,
  output logic [9:0]                             vcount_out,
  output logic                                   is_vertex,
  output logic [SUM_WIDTH-1:0]                   fill_count
);

  localparam int unsigned Center = KERNEL_SIZE / 2;
  localparam int unsigned ColW   = $clog2(KERNEL_SIZE + 1);
  localparam int unsigned FillW  = $clog2(KERNEL_SIZE + 1);

  // Stage 1: threshold and popcount
  logic [ColW-1:0] col_cnt_d;
  logic            ctr_bit_d;

  logic            s1_valid_q;
  logic [ColW-1:0] s1_cnt_q;
  logic            s1_ctr_q;
  logic [10:0]     s1_h_q;
  logic [9:0]      s1_v_q;

  always_comb begin
    col_cnt_d = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      col_cnt_d = col_cnt_d + ColW'(data_in[i] >= on_thresh);
    end
    ctr_bit_d = data_in[Center] >= on_thresh;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_ctr_q   <= 1'b0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
    end else begin
      s1_valid_q <= data_valid_in;
      if (data_valid_in) begin
        s1_cnt_q <= col_cnt_d;
        s1_ctr_q <= ctr_bit_d;
        s1_h_q   <= hcount_in;
        s1_v_q   <= vcount_in;
      end
    end
  end

  // Stage 2: sliding window of column counts and centre bits
  logic [KERNEL_SIZE-1:0][ColW-1:0] cnt_sr_q, cnt_sr_d;
  logic [KERNEL_SIZE-1:0]           ctr_sr_q, ctr_sr_d;
  logic [SUM_WIDTH-1:0]             sum_q, sum_d;
  logic [FillW-1:0]                 fill_q, fill_d;
  logic                             s2_valid_q;
  logic [10:0]                      s2_h_q;
  logic [9:0]                       s2_v_q;
  logic                             restart;

  // s2_v_q holds the vcount of the previous valid column, so a row change is visible here.
  assign restart = (s1_h_q == '0) || (s1_v_q != s2_v_q);

  always_comb begin
    cnt_sr_d = cnt_sr_q;
    ctr_sr_d = ctr_sr_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    if (s1_valid_q) begin
      if (restart) begin
        cnt_sr_d    = '0;
        cnt_sr_d[0] = s1_cnt_q;
        sum_d       = SUM_WIDTH'(s1_cnt_q);
        fill_d      = FillW'(1);
      end else begin
        cnt_sr_d = {cnt_sr_q[KERNEL_SIZE-2:0], s1_cnt_q};
        sum_d    = sum_q + SUM_WIDTH'(s1_cnt_q) - SUM_WIDTH'(cnt_sr_q[KERNEL_SIZE-1]);
        fill_d   = (fill_q == FillW'(KERNEL_SIZE)) ? fill_q : fill_q + FillW'(1);
      end
      ctr_sr_d = {ctr_sr_q[KERNEL_SIZE-2:0], s1_ctr_q};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_sr_q   <= '0;
      ctr_sr_q   <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_h_q     <= '0;
      s2_v_q     <= '0;
    end else begin
      cnt_sr_q   <= cnt_sr_d;
      ctr_sr_q   <= ctr_sr_d;
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_h_q <= s1_h_q;
        s2_v_q <= s1_v_q;
      end
    end
  end

  // Stage 3: compare and register outputs
  logic window_full;
  logic vertex_d;

  always_comb begin
    window_full = (fill_q == FillW'(KERNEL_SIZE)) && (s2_v_q >= 10'(KERNEL_SIZE - 1));
    vertex_d    = s2_valid_q && window_full && ctr_sr_q[Center] &&
                  ((mode[0] && (sum_q <= convex_max)) || (mode[1] && (sum_q >= concave_min)));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_valid_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      is_vertex      <= 1'b0;
      fill_count     <= '0;
    end else begin
      data_valid_out <= s2_valid_q;
      hcount_out     <= s2_h_q - 11'(Center);
      vcount_out     <= s2_v_q - 10'(Center);
      is_vertex      <= vertex_d;
      fill_count     <= sum_q;
    end
  end

endmodule

// File: tb/tb_vertex_detection_param.sv
// Bench for vertex_detection_param (KERNEL_SIZE=5): synthetic mask frames, image-based reference
// model feeding a scoreboard, plus a table of per-frame hit counts and probe points.
`timescale 1ns / 1ps
module tb_vertex_detection_param;

  localparam int unsigned K  = 5;
  localparam int unsigned PW = 16;
  localparam int unsigned SW = 5;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic [K-1:0][PW-1:0]    data_in;
  logic [10:0]             hcount_in;
  logic [9:0]              vcount_in;
  logic                    data_valid_in;
  logic [PW-1:0]           on_thresh;
  logic [SW-1:0]           convex_max;
  logic [SW-1:0]           concave_min;
  logic [1:0]              mode;
  logic                    data_valid_out;
  logic [10:0]             hcount_out;
  logic [9:0]              vcount_out;
  logic                    is_vertex;
  logic [SW-1:0]           fill_count;

  vertex_detection_param #(
    .KERNEL_SIZE(K),
    .PIXEL_WIDTH(PW),
    .SUM_WIDTH  (SW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .data_valid_in (data_valid_in),
    .on_thresh     (on_thresh),
    .convex_max    (convex_max),
    .concave_min   (concave_min),
    .mode          (mode),
    .data_valid_out(data_valid_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .is_vertex     (is_vertex),
    .fill_count    (fill_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [10:0]   h;
    logic [9:0]    v;
    logic          vx;
    logic [SW-1:0] fill;
    int            cyc;
  } exp_t;

  typedef struct {
    int       img;
    bit [1:0] md;
    int       thr;
    int       cmax;
    int       cmin;
    bit       gaps;
    int       exp_hits;   // -1: not checked
    int       ph;
    int       pv;
    int       pfill;
    bit       pvx;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hits;
  int   probe_h, probe_v, probe_fill;
  bit   probe_seen, probe_vx;

  int   cfg_thr, cfg_cmax, cfg_cmin;
  bit [1:0] cfg_mode;
  int   m_n, m_prev_v;

  function automatic bit img(input int id, input int x, input int y);
    case (id)
      0:       return (x <= 20) && (y <= 30);
      1:       return !((x > 20) && (y > 30));
      2:       return y <= 30;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard consumer
  always @(posedge clk_in) begin
    #1;
    if (!rst_in && data_valid_out) begin
      if (is_vertex) hits++;
      if (hcount_out == 11'(probe_h) && vcount_out == 10'(probe_v)) begin
        probe_seen = 1'b1;
        probe_fill = int'(fill_count);
        probe_vx   = is_vertex;
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got valid at h=%0d v=%0d required no output",
                 hcount_out, vcount_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hcount_out != e.h || vcount_out != e.v || is_vertex != e.vx ||
            fill_count != e.fill || cyc != e.cyc) begin
          bad++;
          $display("FAIL out_word: got h=%0d v=%0d vx=%0d fill=%0d cyc=%0d required h=%0d v=%0d vx=%0d fill=%0d cyc=%0d",
                   hcount_out, vcount_out, is_vertex, fill_count, cyc,
                   e.h, e.v, e.vx, e.fill, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      data_valid_in = 1'b0;
      for (int i = 0; i < K; i++) data_in[i] = 16'($urandom);
      hcount_in = 11'($urandom);
    end
  endtask

  task automatic drive_col(input int id, input int h, input int v);
    exp_t e;
    int   c;
    int   y;
    @(negedge clk_in);
    for (int i = 0; i < K; i++) begin
      y = v - i;
      if (y >= 0 && img(id, h, y)) data_in[i] = 16'(cfg_thr + int'($urandom_range(0, 15)));
      else data_in[i] = 16'($urandom_range(0, cfg_thr - 1));
    end
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    data_valid_in = 1'b1;
    if (h == 0 || v != m_prev_v) m_n = 1;
    else if (m_n < K) m_n++;
    m_prev_v = v;
    c = 0;
    for (int x = h - m_n + 1; x <= h; x++)
      for (int yy = v - 4; yy <= v; yy++)
        if (yy >= 0 && img(id, x, yy)) c++;
    e.h    = 11'(h - 2);
    e.v    = 10'(v - 2);
    e.fill = SW'(c);
    e.vx   = (m_n == K) && (v >= 4) && img(id, h - 2, v - 2) &&
             ((cfg_mode[0] && c <= cfg_cmax) || (cfg_mode[1] && c >= cfg_cmin));
    e.cyc  = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic configure(input int thr, input bit [1:0] md, input int cmax, input int cmin);
    @(negedge clk_in);
    cfg_thr = thr; cfg_mode = md; cfg_cmax = cmax; cfg_cmin = cmin;
    on_thresh   = 16'(thr);
    mode        = md;
    convex_max  = SW'(cmax);
    concave_min = SW'(cmin);
  endtask

  task automatic run_frame(input int id, input bit gaps);
    for (int v = 0; v < 36; v++)
      for (int h = 0; h < 40; h++) begin
        drive_col(id, h, v);
        if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
      end
    idle(6);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{0, 2'd1,   1,  9, 18, 1'b0,    1, 20, 30,  9, 1'b1};
    tbl[1] = '{0, 2'd1,   1,  9, 18, 1'b1,    1, 20, 30,  9, 1'b1};
    tbl[2] = '{0, 2'd1, 128,  9, 18, 1'b0,    1, 20, 30,  9, 1'b1};
    tbl[3] = '{1, 2'd2,   1,  9, 18, 1'b0,   -1, 20, 30, 21, 1'b1};
    tbl[4] = '{1, 2'd1,   1,  9, 18, 1'b1,    0, 20, 30, 21, 1'b0};
    tbl[5] = '{2, 2'd1,   1,  9, 18, 1'b0,    0, 20, 30, 15, 1'b0};
    tbl[6] = '{3, 2'd2,   1,  9, 18, 1'b1, 1152, 20, 20, 25, 1'b1};
    tbl[7] = '{3, 2'd0,   1,  9, 18, 1'b0,    0, 20, 20, 25, 1'b0};
    tbl[8] = '{2, 2'd3,   1, 20, 15, 1'b0,   -1, 20, 30, 15, 1'b1};
    tbl[9] = '{3, 2'd3,   1,  9, 18, 1'b0, 1152, 20, 20, 25, 1'b1};

    rst_in = 1'b1; data_valid_in = 1'b0; data_in = '0; hcount_in = '0; vcount_in = '0;
    on_thresh = 16'd1; convex_max = SW'(9); concave_min = SW'(18); mode = 2'd3;
    cfg_thr = 1; cfg_mode = 2'd3; cfg_cmax = 9; cfg_cmin = 18;
    m_n = 0; m_prev_v = 0; hits = 0; probe_h = -1; probe_v = -1;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs", int'({data_valid_out, hcount_out, vcount_out, is_vertex, fill_count}), 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    foreach (tbl[t]) begin
      configure(tbl[t].thr, tbl[t].md, tbl[t].cmax, tbl[t].cmin);
      hits = 0; probe_seen = 1'b0; probe_h = tbl[t].ph; probe_v = tbl[t].pv;
      run_frame(tbl[t].img, tbl[t].gaps);
      if (tbl[t].exp_hits >= 0) check($sformatf("hits_row%0d", t), hits, tbl[t].exp_hits);
      check($sformatf("probe_seen_row%0d", t), int'(probe_seen), 1);
      check($sformatf("probe_fill_row%0d", t), probe_fill, tbl[t].pfill);
      check($sformatf("probe_vx_row%0d", t), int'(probe_vx), int'(tbl[t].pvx));
    end

    // Row change without hcount returning to 0 must restart the window.
    configure(1, 2'd2, 9, 18);
    hits = 0;
    for (int h = 0; h < 8; h++) drive_col(3, h, 10);
    for (int h = 3; h < 13; h++) drive_col(3, h, 11);
    idle(6);
    check("vcount_restart_hits", hits, 10);

    // Mid-row reset, then resume mid-row: needs 5 fresh columns before a vertex.
    for (int h = 0; h < 10; h++) drive_col(3, h, 32);
    @(negedge clk_in);
    rst_in = 1'b1; data_valid_in = 1'b0;
    sb.delete();
    m_n = 0; m_prev_v = 0;
    @(posedge clk_in); #1;
    check("midreset_cycle1", int'({data_valid_out, hcount_out, vcount_out, is_vertex, fill_count}), 0);
    @(posedge clk_in); #1;
    check("midreset_cycle2", int'({data_valid_out, hcount_out, vcount_out, is_vertex, fill_count}), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    hits = 0; probe_seen = 1'b0; probe_h = 12; probe_v = 30;
    for (int h = 10; h < 40; h++) drive_col(3, h, 32);
    idle(6);
    check("post_reset_hits", hits, 26);
    check("post_reset_first_vx", int'(probe_seen && probe_vx), 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vertex_detection_param.md
Name: vertex_detection_param

Overview:
- Parametrised streaming vertex (corner) detector for binary or near-binary mask video.
- Consumes one KERNEL_SIZE-tall pixel column per valid cycle from the upstream line buffer and keeps a sliding KERNEL_SIZE x KERNEL_SIZE window.
- Counts the "on" pixels in the window. Flags the window centre as a convex vertex (low fill), a concave vertex (high fill), or either, depending on a runtime mode.
- Sits between the line buffer and the vertex/centroid tracker, and replaces the fixed-size vertex_detection.

Parameters:
- KERNEL_SIZE, 11, window side; odd and at least 3. CENTER = KERNEL_SIZE/2 (integer division).
- PIXEL_WIDTH, 16, bits per input pixel.
- SUM_WIDTH, $clog2(KERNEL_SIZE*KERNEL_SIZE+1), width of the window on-count.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- data_in, input, KERNEL_SIZE x PIXEL_WIDTH, one column. Index 0 is the newest row (vcount_in); index KERNEL_SIZE-1 is the oldest row.
- hcount_in, input, 11, column of data_in.
- vcount_in, input, 10, row of data_in[0].
- data_valid_in, input, 1, column valid.
- on_thresh, input, PIXEL_WIDTH, a pixel is on when its unsigned value >= on_thresh.
- convex_max, input, SUM_WIDTH, convex vertex when count <= convex_max.
- concave_min, input, SUM_WIDTH, concave vertex when count >= concave_min.
- mode, input, 2, detection mode: 0 = off, 1 = convex, 2 = concave, 3 = both.
- data_valid_out, output, 1, output valid.
- hcount_out, output, 11, window-centre column.
- vcount_out, output, 10, window-centre row.
- is_vertex, output, 1, centre pixel is a vertex.
- fill_count, output, SUM_WIDTH, window on-count for debug and tuning.

Behaviour:
- Reset: all outputs are registered and reset to 0. The column history, column counts, running sum and fill counter reset to 0. Reset mid-frame discards the window; detection restarts on the next column stream.
- Pipeline latency is exactly 3 cycles from data_valid_in to data_valid_out. data_valid_out equals data_valid_in delayed 3 cycles, with no bubbles inserted.
- Stage 1, on each valid cycle:
  - Threshold every pixel to 1 bit.
  - Popcount the column into col_cnt (width $clog2(KERNEL_SIZE+1)).
  - Capture the column's centre bit data_in[CENTER].
  - Register hcount and vcount.
- Stage 2, window update:
  - Shift col_cnt into a KERNEL_SIZE-deep count shift register.
  - Update the running sum: sum_next = sum + new - oldest.
  - Shift centre bits into a KERNEL_SIZE-deep bit shift register.
  - The window centre is the entry CENTER columns back.
- Stage 3, compare:
  - fill_count = sum.
  - is_vertex = window_full AND centre_on AND ((mode[0] AND sum <= convex_max) OR (mode[1] AND sum >= concave_min)).
- Output coordinates:
  - hcount_out = registered hcount - CENTER.
  - vcount_out = registered vcount - CENTER.
  - When window_full is 0, coordinates are still driven. is_vertex is forced 0 and no out-of-range correctness is required.
- Idle cycles: when data_valid_in is 0, window state (shift registers, sum, fill counter) holds unchanged. The stage valid bits still advance.
- Window fill counter:
  - Counts valid columns since the row started and saturates at KERNEL_SIZE.
  - Resets to 1 on a valid column with hcount_in == 0; that column becomes the first column of the new row.
  - Also resets to 1 when vcount_in differs from the previous valid column's vcount.
  - On either restart, the count shift register and sum are cleared before the new column is added, so no cross-row mixing occurs.
- window_full = (fill counter == KERNEL_SIZE) AND (vcount >= KERNEL_SIZE-1).
- Threshold and mode ports are sampled by the stage that uses them; changes take effect on the next column. convex_max >= concave_min is legal: a count meeting both conditions is a vertex under mode 3.
- Sum arithmetic is unsigned. With correct add/subtract the sum never exceeds KERNEL_SIZE^2 and never underflows.

Test Plan (KERNEL_SIZE=5, on_thresh=1, convex_max=9, concave_min=18, mode=3 unless stated):
- Reset: assert rst_in mid-stream for 2 cycles -> all outputs 0. First vertex is reported only after 5 fresh valid columns.
- Convex corner: filled quadrant with its corner at (20,30), i.e. on for x<=20, y<=30 -> exactly one is_vertex, at hcount_out=20, vcount_out=30, fill_count=9. Latency is 3 cycles after the column at hcount_in=22.
- Concave corner: all on except x>20, y>30 -> is_vertex at (20,30) with fill_count=21. mode=1 suppresses it; mode=2 reports it.
- Straight edge: on for y<=30 -> fill_count=15 along row 30 and is_vertex stays 0 everywhere.
- Row wrap and stall: insert data_valid_in=0 gaps of 1-4 cycles mid-row -> same detections as the gap-free run. hcount_in=0 on a new row clears the window, so there is no vertex for the first 4 columns of the row.
- Edge of frame: all-on frame -> fill_count=25 and is_vertex=1 only under mode 2 or 3. is_vertex=0 whenever vcount_in<4 or fewer than 5 columns have been seen in the row.
